// File: rtl/cdb_arbiter_pkg.sv
// Shared out-of-order core configuration: widths and the payload structs
// that move between reservation stations, functional units and the CDB.
package ooo_config;

  localparam int PHYS_BITS = 6;
  localparam int ROB_BITS  = 5;
  localparam int BRU_BITS  = 2;
  localparam int BRU_DEPTH = 1 << BRU_BITS;

  typedef struct packed {
    logic [PHYS_BITS-1:0] pd;
    logic [ROB_BITS-1:0]  rob_idx;
    logic [31:0]          data;
    logic [BRU_DEPTH-1:0] br_mask;
  } cdb_entry_t;

  typedef struct packed {
    logic                 valid;
    logic [6:0]           op;
    logic [PHYS_BITS-1:0] pd;
    logic [PHYS_BITS-1:0] ps1;
    logic [PHYS_BITS-1:0] ps2;
    logic                 ps1_ready;
    logic                 ps2_ready;
    logic [ROB_BITS-1:0]  rob_idx;
    logic [BRU_DEPTH-1:0] br_mask;
  } resv_entry_t;

  // Mask that drops one branch-dependence bit; all-ones when nothing resolves.
  function automatic logic [BRU_DEPTH-1:0] resolve_keep_mask(
    input logic               resolve,
    input logic [BRU_BITS-1:0] idx
  );
    resolve_keep_mask = resolve ? ~(BRU_DEPTH'(1) << idx) : '1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Round-robin one-hot picker: first live bit at or above ptr, wrapping.
module rr_picker #(
  parameter int NUM_FU   = 4,
  parameter int PTR_BITS = 2
) (
  input  logic [NUM_FU-1:0]   live,
  input  logic [PTR_BITS-1:0] ptr,
  output logic [NUM_FU-1:0]   grant
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!found && live[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: zero-cycle round-robin grant among functional
// units, one registered broadcast slot with branch kill/resolve handling.
module cdb_arbiter
  import ooo_config::*;
#(
  parameter int NUM_FU = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_FU-1:0]                   req_valid,
  input  logic [NUM_FU-1:0][PHYS_BITS-1:0]    req_pd,
  input  logic [NUM_FU-1:0][ROB_BITS-1:0]     req_rob_idx,
  input  logic [NUM_FU-1:0][31:0]             req_data,
  input  logic [NUM_FU-1:0][BRU_DEPTH-1:0]    req_br_mask,
  output logic [NUM_FU-1:0]                   req_ready,
  input  logic                                br_valid,
  input  logic                                br_mispred,
  input  logic [BRU_BITS:0]                   br_idx,
  output logic                                cdb_valid,
  output logic [PHYS_BITS-1:0]                cdb_pd,
  output logic [ROB_BITS-1:0]                 cdb_rob_idx,
  output logic [31:0]                         cdb_data,
  output logic [BRU_DEPTH-1:0]                cdb_br_mask
);

  localparam int PTR_BITS = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [BRU_BITS-1:0]  br_sel;
  logic                 unused_br_msb;
  logic [NUM_FU-1:0]    kill;
  logic [NUM_FU-1:0]    live;
  logic [NUM_FU-1:0]    grant;
  logic [PTR_BITS-1:0]  rr_ptr;
  logic [PTR_BITS-1:0]  win_idx;
  logic [PTR_BITS-1:0]  ptr_next;
  logic [BRU_DEPTH-1:0] keep_mask;
  cdb_entry_t           sel_entry;
  cdb_entry_t           cdb_q;

  assign br_sel        = br_idx[BRU_BITS-1:0];
  assign unused_br_msb = br_idx[BRU_BITS];
  assign keep_mask     = resolve_keep_mask(br_valid & ~br_mispred, br_sel);

  // Gating live with rst keeps req_ready low for the whole reset window.
  always_comb begin
    kill = '0;
    for (int i = 0; i < NUM_FU; i++)
      kill[i] = br_valid & br_mispred & req_br_mask[i][br_sel];
    live = req_valid & ~kill & {NUM_FU{rst}};
  end

  rr_picker #(
    .NUM_FU   (NUM_FU),
    .PTR_BITS (PTR_BITS)
  ) u_picker (
    .live  (live),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign req_ready = grant;

  always_comb begin
    win_idx   = '0;
    sel_entry = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        win_idx   = PTR_BITS'(i);
        sel_entry = '{pd: req_pd[i], rob_idx: req_rob_idx[i],
                      data: req_data[i], br_mask: req_br_mask[i]};
      end
    end
    ptr_next = (win_idx == PTR_BITS'(NUM_FU - 1)) ? '0 : win_idx + 1'b1;
  end

  // Broadcast lives exactly one cycle; a held killed result simply lapses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cdb_valid     <= 1'b0;
      rr_ptr        <= '0;
      cdb_q.br_mask <= '0;
    end else begin
      cdb_valid <= |grant;
      if (|grant) begin
        cdb_q         <= sel_entry;
        cdb_q.br_mask <= sel_entry.br_mask & keep_mask;
        rr_ptr        <= ptr_next;
      end else begin
        cdb_q.br_mask <= cdb_q.br_mask & keep_mask;
      end
    end
  end

  assign cdb_pd      = cdb_q.pd;
  assign cdb_rob_idx = cdb_q.rob_idx;
  assign cdb_data    = cdb_q.data;
  assign cdb_br_mask = cdb_q.br_mask;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: grants checked in-cycle, broadcasts
// checked by a monitor against a queue of expected CDB entries.
module tb_cdb_arbiter;
  import ooo_config::*;

  localparam int NUM_FU = 4;

  logic                             clk = 1'b0;
  logic                             rst;
  logic [NUM_FU-1:0]                req_valid;
  logic [NUM_FU-1:0][PHYS_BITS-1:0] req_pd;
  logic [NUM_FU-1:0][ROB_BITS-1:0]  req_rob_idx;
  logic [NUM_FU-1:0][31:0]          req_data;
  logic [NUM_FU-1:0][BRU_DEPTH-1:0] req_br_mask;
  logic [NUM_FU-1:0]                req_ready;
  logic                             br_valid;
  logic                             br_mispred;
  logic [BRU_BITS:0]                br_idx;
  logic                             cdb_valid;
  logic [PHYS_BITS-1:0]             cdb_pd;
  logic [ROB_BITS-1:0]              cdb_rob_idx;
  logic [31:0]                      cdb_data;
  logic [BRU_DEPTH-1:0]             cdb_br_mask;

  cdb_entry_t expQ[$];
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_FU(NUM_FU)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_pd      (req_pd),
    .req_rob_idx (req_rob_idx),
    .req_data    (req_data),
    .req_br_mask (req_br_mask),
    .req_ready   (req_ready),
    .br_valid    (br_valid),
    .br_mispred  (br_mispred),
    .br_idx      (br_idx),
    .cdb_valid   (cdb_valid),
    .cdb_pd      (cdb_pd),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_data    (cdb_data),
    .cdb_br_mask (cdb_br_mask)
  );

  function automatic cdb_entry_t mkExp(input int fu, input logic [BRU_DEPTH-1:0] mask);
    mkExp = '{pd: req_pd[fu], rob_idx: req_rob_idx[fu], data: req_data[fu], br_mask: mask};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic checkOutput(input logic [NUM_FU-1:0] expReady, input int expCdbv);
    check("req_ready", 64'(req_ready), 64'(expReady));
    if (expCdbv >= 0) check("cdb_valid", 64'(cdb_valid), 64'(expCdbv));
  endtask

  // Drives one cycle of requests/branch info, checks at the falling edge.
  task automatic applyStimulus(input logic [NUM_FU-1:0] valid, input logic bv,
                               input logic bm, input logic [BRU_BITS:0] bidx,
                               input logic [NUM_FU-1:0] expReady, input int expCdbv);
    req_valid  = valid;
    br_valid   = bv;
    br_mispred = bm;
    br_idx     = bidx;
    @(negedge clk);
    checkOutput(expReady, expCdbv);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every broadcast must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (cdb_valid === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin
          $display("[TB] FAIL unexpected_broadcast: got rob %0h expected no broadcast", cdb_rob_idx);
        end else begin
          cdb_entry_t e;
          e = expQ.pop_front();
          if (cdb_pd === e.pd && cdb_rob_idx === e.rob_idx &&
              cdb_data === e.data && cdb_br_mask === e.br_mask)
            passes++;
          else
            $display("[TB] FAIL cdb_payload: got pd=%0h rob=%0h data=%0h mask=%b expected pd=%0h rob=%0h data=%0h mask=%b",
                     cdb_pd, cdb_rob_idx, cdb_data, cdb_br_mask, e.pd, e.rob_idx, e.data, e.br_mask);
        end
      end
    end
  end

  initial begin
    rst        = 1'b0;
    req_valid  = '1;
    br_valid   = 1'b0;
    br_mispred = 1'b0;
    br_idx     = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      req_pd[i]      = PHYS_BITS'(i + 1);
      req_rob_idx[i] = ROB_BITS'(i + 8);
      req_data[i]    = 32'hA0 + 32'(i);
      req_br_mask[i] = '0;
    end
    #1;

    // Reset with everyone requesting
    applyStimulus(4'b1111, 0, 0, 0, 4'b0000, 0);
    applyStimulus(4'b1111, 0, 0, 0, 4'b0000, 0);
    rst = 1'b1;

    // Fairness
    for (int i = 0; i < 8; i++) begin
      expQ.push_back(mkExp(i % 4, 4'b0000));
      applyStimulus(4'b1111, 0, 0, 0, 4'b0001 << (i % 4), (i == 0) ? 0 : 1);
    end
    applyStimulus(4'b0000, 0, 0, 0, 4'b0000, 1);

    // Move pointer to 1, then mispredict kills FU1
    expQ.push_back(mkExp(0, 4'b0000));
    applyStimulus(4'b0001, 0, 0, 0, 4'b0001, 0);
    req_br_mask[1] = 4'b0100;
    expQ.push_back(mkExp(2, 4'b0000));
    applyStimulus(4'b0110, 1, 1, 3'd2, 4'b0100, 1);
    req_br_mask[1] = 4'b0000;
    expQ.push_back(mkExp(3, 4'b0000));
    applyStimulus(4'b1111, 0, 0, 0, 4'b1000, 1);

    // Held-output kill
    req_br_mask[3] = 4'b0010;
    expQ.push_back(mkExp(3, 4'b0010));
    applyStimulus(4'b1000, 0, 0, 0, 4'b1000, 1);
    req_br_mask[3] = 4'b0000;
    applyStimulus(4'b0000, 1, 1, 3'd1, 4'b0000, 1);
    applyStimulus(4'b0000, 0, 0, 0, 4'b0000, 0);

    // Correct resolve clears the captured bit; non-matching mispredict does not kill
    req_br_mask[0] = 4'b0011;
    expQ.push_back(mkExp(0, 4'b0010));
    applyStimulus(4'b0001, 1, 0, 3'd0, 4'b0001, 0);
    expQ.push_back(mkExp(0, 4'b0011));
    applyStimulus(4'b0001, 1, 1, 3'd3, 4'b0001, 1);
    req_br_mask[0] = 4'b0000;

    // Only the low index bits select the branch
    req_br_mask[2] = 4'b0100;
    applyStimulus(4'b0100, 1, 1, 3'b110, 4'b0000, 1);
    req_br_mask[2] = 4'b0000;

    // Pointer held at 1 across the killed cycle; pd=0 still broadcasts
    req_pd[1] = '0;
    expQ.push_back(mkExp(1, 4'b0000));
    applyStimulus(4'b1111, 0, 0, 0, 4'b0010, 0);
    req_pd[1] = PHYS_BITS'(2);

    // Single requester streams back-to-back
    for (int k = 0; k < 5; k++) begin
      req_data[2] = 32'h10 + 32'(k);
      expQ.push_back(mkExp(2, 4'b0000));
      applyStimulus(4'b0100, 0, 0, 0, 4'b0100, 1);
    end

    // Mid-stream reset, then FU0 has priority again
    rst = 1'b0;
    applyStimulus(4'b1111, 0, 0, 0, 4'b0000, 1);
    applyStimulus(4'b1111, 0, 0, 0, 4'b0000, 0);
    rst = 1'b1;
    expQ.push_back(mkExp(0, 4'b0000));
    applyStimulus(4'b1111, 0, 0, 0, 4'b0001, 0);
    applyStimulus(4'b0000, 0, 0, 0, 4'b0000, 1);
    applyStimulus(4'b0000, 0, 0, 0, 4'b0000, 0);

    check("scoreboard_drained", 64'(expQ.size()), 64'd0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
